// File: rtl/loop_chk_pkg.sv
// Shared types and constants for the loop exit checker: FSM states, error codes,
// loop step sizes and the counter width.
package loop_chk_pkg;

  localparam int CNT_W  = 16;
  localparam int STEP_I = 2;
  localparam int STEP_J = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_INIT     = 3'd1,
    ERR_STEP     = 3'd2,
    ERR_INVAR    = 3'd3,
    ERR_EXITVAL  = 3'd4,
    ERR_COUNT    = 3'd5,
    ERR_OVERSTEP = 3'd6
  } err_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/loop_step_predict.sv
// Combinational prediction of the loop stage's next i/j from the previous sample
// and the selector the stage was driven with.
module loop_step_predict
  import loop_chk_pkg::*;
#(
  parameter int W = 15
) (
  input  logic [W-1:0] prev_i,
  input  logic [W-1:0] prev_j,
  input  logic         sel_q,
  output logic         active,
  output logic [W-1:0] exp_i,
  output logic [W-1:0] exp_j
);

  // Unsigned compare; arithmetic wraps mod 2^W so a broken stage shows up as a mismatch.
  assign active = sel_q && (prev_j >= prev_i);
  assign exp_i  = active ? prev_i + W'(STEP_I) : prev_i;
  assign exp_j  = active ? prev_j - W'(STEP_J) : prev_j;

endmodule

// File: rtl/loop_exit_checker.sv
// Passive monitor for the i/j loop stage: checks every transition, the exit point and step count.
// Optional invariant check (i + 2*j constant) is built when LOOP_CHK_INVARIANT_EN is defined.
module loop_exit_checker
  import loop_chk_pkg::*;
#(
  parameter int W           = 15,
  parameter int I_INIT      = 1,
  parameter int J_INIT      = 1000,
  parameter int EXIT_I      = 669,
  parameter int EXIT_J      = 666,
  parameter int EXIT_STEPS  = 334,
  parameter int STALL_LIMIT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic [W-1:0] i_val,
  input  logic [W-1:0] j_val,
  output logic [1:0]   state,
  output logic [15:0]  step_cnt,
  output logic         stalled,
  output logic         done,
  output logic         err_valid,
  output logic [2:0]   err_code
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               stalled_q, stalled_d;
  logic               done_q, done_d;
  logic               err_valid_q, err_valid_d;
  err_t               err_code_q, err_code_d;
  logic               sel_q, sel_d;
  logic [W-1:0]       prev_i_q, prev_i_d;
  logic [W-1:0]       prev_j_q, prev_j_d;
  err_t               fail_code;

  logic               active;
  logic [W-1:0]       exp_i;
  logic [W-1:0]       exp_j;
  logic               init_ok;
  logic               step_bad;
  logic               exit_seen;
  logic               exit_val_bad;
  logic               moved;
  logic               inv_bad;

  loop_step_predict #(
    .W(W)
  ) u_predict (
    .prev_i (prev_i_q),
    .prev_j (prev_j_q),
    .sel_q  (sel_q),
    .active (active),
    .exp_i  (exp_i),
    .exp_j  (exp_j)
  );

  assign init_ok      = (i_val == W'(I_INIT)) && (j_val == W'(J_INIT));
  assign step_bad     = (i_val != exp_i) || (j_val != exp_j);
  assign exit_seen    = (i_val > j_val);
  assign exit_val_bad = (i_val != W'(EXIT_I)) || (j_val != W'(EXIT_J));
  assign moved        = (i_val != prev_i_q) || (j_val != prev_j_q);

`ifdef LOOP_CHK_INVARIANT_EN
  // Two extra bits hold i + 2*j without overflow for any W-bit inputs.
  localparam logic [W+1:0] INV_SUM = (W+2)'(I_INIT + 2 * J_INIT);
  logic [W+1:0] inv_sum;
  assign inv_sum = {2'b00, i_val} + {1'b0, j_val, 1'b0};
  assign inv_bad = (inv_sum != INV_SUM);
`else
  assign inv_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    done_d      = done_q;
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    sel_d       = sel_q;
    prev_i_d    = prev_i_q;
    prev_j_d    = prev_j_q;
    fail_code   = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        // First sample after reset is the stage's freshly loaded initial value.
        if (init_ok) begin
          state_d = ST_RUN;
        end else begin
          fail_code = ERR_INIT;
        end
        prev_i_d = i_val;
        prev_j_d = j_val;
        sel_d    = sel;
      end

      ST_RUN: begin
        if (active) begin
          step_cnt_d = sat_inc(step_cnt_q);
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = sat_inc(idle_cnt_q);
        end

        if (step_bad) begin
          fail_code = ERR_STEP;
        end else if (inv_bad) begin
          fail_code = ERR_INVAR;
        end else if (exit_seen) begin
          if (exit_val_bad) begin
            fail_code = ERR_EXITVAL;
          end else if (step_cnt_d != CNT_W'(EXIT_STEPS)) begin
            fail_code = ERR_COUNT;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end

        prev_i_d = i_val;
        prev_j_d = j_val;
        sel_d    = sel;
      end

      ST_DONE: begin
        // The stage must hold its exit values; sel no longer matters.
        if (inv_bad) begin
          fail_code = ERR_INVAR;
        end else if (moved) begin
          fail_code = ERR_OVERSTEP;
        end
      end

      default: begin
      end
    endcase

    if (fail_code != ERR_NONE) begin
      state_d     = ST_FAIL;
      err_valid_d = 1'b1;
      if (!err_valid_q) begin
        err_code_d = fail_code;
      end
    end

    stalled_d = (state_d == ST_RUN) && (idle_cnt_d >= CNT_W'(STALL_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      stalled_q   <= 1'b0;
      done_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      sel_q       <= 1'b0;
      prev_i_q    <= '0;
      prev_j_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      stalled_q   <= stalled_d;
      done_q      <= done_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      sel_q       <= sel_d;
      prev_i_q    <= prev_i_d;
      prev_j_q    <= prev_j_d;
    end
  end

  assign state     = state_q;
  assign step_cnt  = step_cnt_q;
  assign stalled   = stalled_q;
  assign done      = done_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_loop_exit_checker.sv
// Scoreboard bench for loop_exit_checker: the bench plays the loop stage, a reference
// model predicts the checker's outputs per edge, and a monitor compares them.
module tb_loop_exit_checker;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic [W-1:0] i_val = '0;
  logic [W-1:0] j_val = '0;
  logic [1:0]   state;
  logic [15:0]  step_cnt;
  logic         stalled;
  logic         done;
  logic         err_valid;
  logic [2:0]   err_code;

  always #5 clk = ~clk;

  loop_exit_checker dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .i_val     (i_val),
    .j_val     (j_val),
    .state     (state),
    .step_cnt  (step_cnt),
    .stalled   (stalled),
    .done      (done),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  typedef struct {
    int st; int cnt; int stl; int dn; int ev; int ec;
    bit fin; int id; int f_st; int f_ec; int f_ev; bit use_cnt; int f_cnt;
    bit stall_clr; bit stall_chk; int stall_exp;
    bit last;
  } exp_t;

  exp_t q[$];

  // Loop stage as the bench drives it.
  int ls_i = 0, ls_j = 0, ls_steps = 0;

  // Reference model of the checker's registered outputs.
  int m_st = 0, m_cnt = 0, m_idle = 0, m_stl = 0, m_dn = 0, m_ev = 0, m_ec = 0;
  int m_pi = 0, m_pj = 0, m_sq = 0;

  int errors = 0;
  int checks = 0;

  task automatic model_fail(input int code);
    m_st = 3;
    if (m_ev == 0) m_ec = code;
    m_ev = 1;
  endtask

  task automatic model_apply(input bit r, input bit s, input int pi, input int pj);
    int ei, ej, code, sum;
    bit act;
    sum = pi + 2 * pj;
    if (r) begin
      m_st = 0; m_cnt = 0; m_idle = 0; m_stl = 0; m_dn = 0; m_ev = 0; m_ec = 0;
      m_pi = 0; m_pj = 0; m_sq = 0;
      return;
    end
    case (m_st)
      0: begin
        if (pi == 1 && pj == 1000) m_st = 1;
        else model_fail(1);
        m_pi = pi; m_pj = pj; m_sq = int'(s);
      end
      1: begin
        act = (m_sq != 0) && (m_pj >= m_pi);
        ei = act ? (m_pi + 2) % 32768 : m_pi;
        ej = act ? (m_pj + 32767) % 32768 : m_pj;
        if (act) begin
          m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
          m_idle = 0;
        end else begin
          m_idle = (m_idle < 65535) ? m_idle + 1 : m_idle;
        end
        code = 0;
        if (pi != ei || pj != ej) code = 2;
`ifdef LOOP_CHK_INVARIANT_EN
        else if (sum != 2001) code = 3;
`endif
        else if (pi > pj) begin
          if (pi != 669 || pj != 666) code = 4;
          else if (m_cnt != 334) code = 5;
        end
        if (code != 0) model_fail(code);
        else if (pi > pj) begin m_st = 2; m_dn = 1; end
        m_pi = pi; m_pj = pj; m_sq = int'(s);
      end
      2: begin
`ifdef LOOP_CHK_INVARIANT_EN
        if (sum != 2001) model_fail(3);
        else
`endif
        if (pi != m_pi || pj != m_pj) model_fail(6);
      end
      default: ;
    endcase
    m_stl = (m_st == 1 && m_idle >= 64) ? 1 : 0;
  endtask

  // One clock of stimulus: present values, predict the checker, advance the loop stage.
  task automatic drive(input bit r, input bit s, input bit fi_en, input int fi,
                       input bit fj_en, input int fj);
    int pi, pj;
    exp_t e;
    @(negedge clk);
    pi = fi_en ? fi : ls_i;
    pj = fj_en ? fj : ls_j;
    rst = r; sel = s; i_val = W'(pi); j_val = W'(pj);
    model_apply(r, s, pi, pj);
    e = '{default: 0};
    e.st = m_st; e.cnt = m_cnt; e.stl = m_stl; e.dn = m_dn; e.ev = m_ev; e.ec = m_ec;
    q.push_back(e);
    if (r) begin
      ls_i = 1; ls_j = 1000; ls_steps = 0;
    end else if (s && ls_j >= ls_i) begin
      ls_i += 2; ls_j -= 1; ls_steps++;
    end
  endtask

  task automatic mark_final(input int id, input int st, input int ec, input int ev,
                            input bit use_cnt, input int cnt);
    q[$].fin = 1; q[$].id = id; q[$].f_st = st; q[$].f_ec = ec; q[$].f_ev = ev;
    q[$].use_cnt = use_cnt; q[$].f_cnt = cnt;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic run_until_steps(input int n);
    for (int k = 0; k < 2000 && ls_steps < n; k++) drive(0, 1, 0, 0, 0, 0);
  endtask

  task automatic run_to_exit(input bit rnd);
    int zrun;
    bit s;
    zrun = 0;
    for (int k = 0; k < 3000 && !(ls_i > ls_j); k++) begin
      s = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (zrun >= 40) s = 1'b1;
      zrun = s ? 0 : zrun + 1;
      drive(0, s, 0, 0, 0, 0);
    end
    for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, expv);
    end
  endtask

  // Stimulus
  initial begin
    int ov_code;
`ifdef LOOP_CHK_INVARIANT_EN
    ov_code = 3;
`else
    ov_code = 6;
`endif
    // 1: continuous sel
    do_reset();
    run_to_exit(1'b0);
    mark_final(1, 2, 0, 0, 1, 334);

    // 2: random gaps, never long enough to stall
    do_reset();
    q[$].stall_clr = 1;
    run_to_exit(1'b1);
    mark_final(2, 2, 0, 0, 1, 334);
    q[$].stall_chk = 1; q[$].stall_exp = 0;

    // 3: stage fails to decrement j on step 100
    do_reset();
    run_until_steps(100);
    drive(0, 1, 0, 0, 1, ls_j + 1);
    for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 0, 0);
    mark_final(3, 3, 2, 1, 0, 0);

    // 4: reset pulse mid-run, then a clean full run
    do_reset();
    run_until_steps(150);
    drive(1, 1, 0, 0, 0, 0);
    run_to_exit(1'b0);
    mark_final(4, 2, 0, 0, 1, 334);

    // 5: 70 idle cycles mid-run raise stalled for exactly 7 cycles
    do_reset();
    run_until_steps(50);
    drive(0, 0, 0, 0, 0, 0);
    q[$].stall_clr = 1;
    for (int k = 1; k < 70; k++) drive(0, 0, 0, 0, 0, 0);
    run_to_exit(1'b0);
    mark_final(5, 2, 0, 0, 1, 334);
    q[$].stall_chk = 1; q[$].stall_exp = 7;

    // 6: i moves after DONE
    drive(0, 1, 1, 671, 0, 0);
    drive(0, 1, 1, 671, 0, 0);
    mark_final(6, 3, ov_code, 1, 0, 0);
    q[$].last = 1;
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    int stall_seen;
    stall_seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.stall_clr) stall_seen = 0;
        chk("state", int'(state), e.st);
        chk("step_cnt", int'(step_cnt), e.cnt);
        chk("stalled", int'(stalled), e.stl);
        chk("done", int'(done), e.dn);
        chk("err_valid", int'(err_valid), e.ev);
        chk("err_code", int'(err_code), e.ec);
        if (stalled) stall_seen++;
        if (e.stall_chk) chk("stall_cycles", stall_seen, e.stall_exp);
        if (e.fin) begin
          chk("final_state", int'(state), e.f_st);
          chk("final_err_code", int'(err_code), e.f_ec);
          chk("final_err_valid", int'(err_valid), e.f_ev);
          if (e.use_cnt) chk("final_step_cnt", int'(step_cnt), e.f_cnt);
          $display("scenario %0d: state=%0d step_cnt=%0d done=%0d err_valid=%0d err_code=%0d",
                   e.id, state, step_cnt, done, err_valid, err_code);
        end
        if (e.last) begin
          chk("queue_empty", q.size(), 0);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
